// File: rtl/serial_cascade_compare.sv
// serial_cascade_compare
// Nibble-serial magnitude comparator. Scans the operands one 4-bit nibble per
// clock, starting at the LSB nibble. It produces the same one-hot {GT,LT,EQ}
// cascade code that a 4-bit cascade comparator stage accepts.
// Optional build macro: SERIAL_CMP_SIGNED_EN. When it is defined, the operands
// are two's complement. The sign bit of each operand is flipped when the
// operand is latched.
module serial_cascade_compare #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iCascade,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);
  localparam logic [CW-1:0] K_ONE  = CW'(1);
  localparam logic [CW-1:0] K_ZERO = CW'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One 4-bit slice. The higher nibble decides; on equality the incoming code passes.
  function automatic logic [2:0] sliceCompare(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] cin
  );
    logic [2:0] res;
    if (a > b) begin
      res = 3'b100;
    end else if (a < b) begin
      res = 3'b010;
    end else begin
      res = cin;
    end
    return res;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] dataA_r, dataA_s;
  logic [WIDTH-1:0] dataB_r, dataB_s;
  logic [2:0]       cascade_r, cascade_s;
  logic [CW-1:0]    k_r, k_s;
  logic             busy_s;
  logic             done_s;
  logic [2:0]       result_s;
  logic [WIDTH-1:0] latchA_s;
  logic [WIDTH-1:0] latchB_s;
  logic [2:0]       slice_s;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    latchA_s = iData_a ^ SIGN_MASK;
    latchB_s = iData_b ^ SIGN_MASK;
  end
`else
  // The operands are unsigned, so they are latched unchanged.
  always_comb begin
    latchA_s = iData_a;
    latchB_s = iData_b;
  end
`endif

  // Compare the current nibble. The operand registers shift right, so bits [3:0] hold nibble k.
  always_comb begin
    slice_s = sliceCompare(dataA_r[3:0], dataB_r[3:0], cascade_r);
  end

  // Next-state and next-output logic for the two-state controller.
  always_comb begin
    state_s   = state_r;
    dataA_s   = dataA_r;
    dataB_s   = dataB_r;
    cascade_s = cascade_r;
    k_s       = k_r;
    busy_s    = oBusy;
    done_s    = 1'b0;
    result_s  = oData;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          dataA_s   = latchA_s;
          dataB_s   = latchB_s;
          cascade_s = iCascade;
          k_s       = K_ZERO;
          busy_s    = 1'b1;
          state_s   = RUN;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        cascade_s = slice_s;
        dataA_s   = dataA_r >> 3'd4;
        dataB_s   = dataB_r >> 3'd4;
        if (k_r == LAST_K) begin
          result_s = slice_s;
          done_s   = 1'b1;
          busy_s   = 1'b0;
          k_s      = K_ZERO;
          state_s  = IDLE;
        end else begin
          k_s      = k_r + K_ONE;
          state_s  = RUN;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset aborts any compare in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r   <= IDLE;
      dataA_r   <= '0;
      dataB_r   <= '0;
      cascade_r <= 3'b001;
      k_r       <= K_ZERO;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oData     <= 3'b001;
    end else begin
      state_r   <= state_s;
      dataA_r   <= dataA_s;
      dataB_r   <= dataB_s;
      cascade_r <= cascade_s;
      k_r       <= k_s;
      oBusy     <= busy_s;
      oDone     <= done_s;
      oData     <= result_s;
    end
  end

endmodule

// File: tb/tb_serial_cascade_compare.sv
// Directed, table-driven bench for serial_cascade_compare with WIDTH=16.
module tb_serial_cascade_compare;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iStart;
  logic [15:0] iData_a;
  logic [15:0] iData_b;
  logic [2:0]  iCascade;
  logic        oBusy;
  logic        oDone;
  logic [2:0]  oData;

  int nChecks = 0;
  int nFails  = 0;

  serial_cascade_compare #(.WIDTH(16)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (iStart),
    .iData_a  (iData_a),
    .iData_b  (iData_b),
    .iCascade (iCascade),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oData    (oData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  casc;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Start one compare and check busy/done/data on every edge through the completion.
  task automatic runVector(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] casc, input logic [2:0] exp);
    @(negedge iClk);
    iStart = 1'b1; iData_a = a; iData_b = b; iCascade = casc;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iData_a = ~a; iData_b = ~b; iCascade = 3'b000;
    check({name, " busy@E0"}, {2'b00, oBusy}, 3'b001);
    check({name, " done@E0"}, {2'b00, oDone}, 3'b000);
    for (int e = 1; e <= 4; e++) begin
      @(posedge iClk); #1;
      if (e < 4) begin
        check({name, " busy mid"}, {2'b00, oBusy}, 3'b001);
        check({name, " done mid"}, {2'b00, oDone}, 3'b000);
      end else begin
        check({name, " busy@E4"}, {2'b00, oBusy}, 3'b000);
        check({name, " done@E4"}, {2'b00, oDone}, 3'b001);
        check({name, " data@E4"}, oData, exp);
      end
    end
    @(posedge iClk); #1;
    check({name, " done clears"}, {2'b00, oDone}, 3'b000);
    check({name, " data holds"}, oData, exp);
  endtask

  initial begin
    logic [15:0] pa[2];
    logic [15:0] pb[2];
    logic [2:0]  pe[2];
    int          idx;

    vecs[0] = '{"1234>1230", 16'h1234, 16'h1230, 3'b001, 3'b100};
`ifdef SERIAL_CMP_SIGNED_EN
    vecs[1] = '{"8000vs7FFF", 16'h8000, 16'h7FFF, 3'b001, 3'b010};
    vecs[2] = '{"FFFFvs0000", 16'hFFFF, 16'h0000, 3'b001, 3'b010};
`else
    vecs[1] = '{"8000vs7FFF", 16'h8000, 16'h7FFF, 3'b001, 3'b100};
    vecs[2] = '{"FFFFvs0000", 16'hFFFF, 16'h0000, 3'b001, 3'b100};
`endif
    vecs[3] = '{"BEEF eq casc010", 16'hBEEF, 16'hBEEF, 3'b010, 3'b010};
    vecs[4] = '{"BEEF eq casc001", 16'hBEEF, 16'hBEEF, 3'b001, 3'b001};
    vecs[5] = '{"0F00vs00FF", 16'h0F00, 16'h00FF, 3'b001, 3'b100};
    vecs[6] = '{"1230<1234", 16'h1230, 16'h1234, 3'b001, 3'b010};
    vecs[7] = '{"eq casc111", 16'h0000, 16'h0000, 3'b111, 3'b111};
    vecs[8] = '{"8000<8001", 16'h8000, 16'h8001, 3'b001, 3'b010};
    vecs[9] = '{"top nib only", 16'h1FFF, 16'h2000, 3'b100, 3'b010};

    pa[0] = 16'h1234; pb[0] = 16'h1230; pe[0] = 3'b100;
    pa[1] = 16'h1111; pb[1] = 16'h2222; pe[1] = 3'b010;

    iRst_n = 1'b0; iStart = 1'b0;
    iData_a = 16'h0000; iData_b = 16'h0000; iCascade = 3'b001;
    #12;
    check("reset busy", {2'b00, oBusy}, 3'b000);
    check("reset done", {2'b00, oDone}, 3'b000);
    check("reset data", oData, 3'b001);
    @(negedge iClk);
    iRst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      runVector(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].casc, vecs[i].exp);
    end

    // iStart held high: the block accepts a new pair every 5 edges, and mid-run operands are ignored.
    for (int j = 0; j < 15; j++) begin
      @(negedge iClk);
      iStart = 1'b1;
      idx = (j / 5) % 2;
      if (j % 5 == 0) begin
        iData_a = pa[idx]; iData_b = pb[idx]; iCascade = 3'b001;
      end else begin
        iData_a = 16'h0000; iData_b = 16'h0000; iCascade = 3'b001;
      end
      @(posedge iClk); #1;
      if (j % 5 == 4) begin
        check("stream done", {2'b00, oDone}, 3'b001);
        check("stream busy end", {2'b00, oBusy}, 3'b000);
        check("stream data", oData, pe[idx]);
      end else begin
        check("stream no done", {2'b00, oDone}, 3'b000);
        check("stream busy", {2'b00, oBusy}, 3'b001);
      end
    end
    @(negedge iClk);
    iStart = 1'b0;

    // Abort with reset during the second RUN cycle.
    @(negedge iClk);
    iStart = 1'b1; iData_a = 16'h1230; iData_b = 16'h1234; iCascade = 3'b001;
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(posedge iClk); #3;
    iRst_n = 1'b0;
    #1;
    check("abort busy", {2'b00, oBusy}, 3'b000);
    check("abort done", {2'b00, oDone}, 3'b000);
    check("abort data", oData, 3'b001);
    @(negedge iClk);
    iRst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge iClk); #1;
      check("post-abort no done", {2'b00, oDone}, 3'b000);
      check("post-abort idle", {2'b00, oBusy}, 3'b000);
    end
    runVector("after abort", 16'h0F00, 16'h00FF, 3'b001, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
